// File: rtl/reg_serializer.sv
// Parallel-to-serial converter: captures a WIDTH-bit word on load and shifts it
// out LSB first under a valid/ready handshake, pulsing done after the last bit.
module reg_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             sready,
    output logic             sout,
    output logic             svalid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             svalid_r;
    logic             busy_r;
    logic             done_r;

    logic             xfer_s;
    logic             last_s;

    assign xfer_s = svalid_r & sready;
    assign last_s = xfer_s & (cnt_r == {CW{1'b0}});

    // The shift register drains to zero as it empties, so bit 0 is 0 whenever idle.
    assign sout   = shift_r[0];
    assign svalid = svalid_r;
    assign busy   = busy_r;
    assign done   = done_r;

    // Serializer state machine with registered handshake and completion flags.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r  <= IDLE;
            shift_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            svalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        shift_r  <= in;
                        cnt_r    <= CW'(WIDTH - 1);
                        svalid_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (xfer_s) begin
                        shift_r <= {1'b0, shift_r[WIDTH-1:1]};
                        if (last_s) begin
                            // Counter stays at zero rather than wrapping.
                            svalid_r <= 1'b0;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state_r  <= IDLE;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    shift_r  <= {WIDTH{1'b0}};
                    cnt_r    <= {CW{1'b0}};
                    svalid_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: directed scenarios on a 4-bit instance
// and a randomized sweep on 2-bit and 16-bit instances against a word-level model.
module tb_reg_serializer;

    logic clk;
    logic reset_n;

    logic       load4, sr4;
    logic [3:0] in4;
    logic       sout4, sv4, busy4, done4;

    logic        sw_load, sw_sr;
    logic [15:0] sw_in;
    logic        sout2, sv2, busy2, done2;
    logic        sout16, sv16, busy16, done16;

    int vec_cnt = 0;
    int err_cnt = 0;

    int   xfer_cnt4  = 0;
    int   done_cnt4  = 0;
    int   done_cnt2  = 0;
    int   done_cnt16 = 0;
    logic rx_mem4 [0:255];

    reg_serializer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset_(reset_n), .load(load4), .in(in4), .sready(sr4),
        .sout(sout4), .svalid(sv4), .busy(busy4), .done(done4)
    );

    reg_serializer #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset_(reset_n), .load(sw_load), .in(sw_in[1:0]), .sready(sw_sr),
        .sout(sout2), .svalid(sv2), .busy(busy2), .done(done2)
    );

    reg_serializer #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_(reset_n), .load(sw_load), .in(sw_in), .sready(sw_sr),
        .sout(sout16), .svalid(sv16), .busy(busy16), .done(done16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiver side: record every accepted bit and count done pulses.
    always @(posedge clk) begin
        if (sv4 && sr4) begin
            rx_mem4[xfer_cnt4 % 256] <= sout4;
            xfer_cnt4 <= xfer_cnt4 + 1;
        end
        if (done4)  done_cnt4  <= done_cnt4 + 1;
        if (done2)  done_cnt2  <= done_cnt2 + 1;
        if (done16) done_cnt16 <= done_cnt16 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load4_word(input logic [3:0] w);
        load4 = 1'b1;
        in4   = w;
        @(negedge clk);
        load4 = 1'b0;
        in4   = ~w;
    endtask

    // Entered at the negedge after capture with sr4=1; returns in the done cycle.
    task automatic expect_seq(input logic [3:0] w, input string tag);
        int         start;
        logic [3:0] got;
        start = xfer_cnt4;
        for (int i = 0; i < 4; i++) begin
            check_val({tag, "_sout"}, 32'(sout4), 32'(w[i]));
            check_val({tag, "_svalid"}, 32'(sv4), 32'd1);
            @(negedge clk);
        end
        check_val({tag, "_done"}, 32'(done4), 32'd1);
        check_val({tag, "_busy_end"}, 32'(busy4), 32'd0);
        check_val({tag, "_svalid_end"}, 32'(sv4), 32'd0);
        check_val({tag, "_sout_idle"}, 32'(sout4), 32'd0);
        check_val({tag, "_nbits"}, 32'(xfer_cnt4 - start), 32'd4);
        for (int i = 0; i < 4; i++) got[i] = rx_mem4[(start + i) % 256];
        check_val({tag, "_word"}, 32'(got), 32'(w));
    endtask

    int          rem [2];
    logic [15:0] cur [2];
    logic [15:0] rxw [2];
    logic        done_exp [2];
    int          acc [2];

    task automatic sweep(input int ncyc);
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; cur[k] = 16'h0; rxw[k] = 16'h0; done_exp[k] = 1'b0; acc[k] = 0;
        end
        for (int c = 0; c < ncyc + 24; c++) begin
            logic        o_sout [2];
            logic        o_sv [2];
            logic        o_busy [2];
            logic        o_done [2];
            logic [31:0] mask;
            int          w;
            o_sout[0] = sout2;  o_sv[0] = sv2;  o_busy[0] = busy2;  o_done[0] = done2;
            o_sout[1] = sout16; o_sv[1] = sv16; o_busy[1] = busy16; o_done[1] = done16;
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? 2 : 16;
                check_val($sformatf("sw%0d_svalid", w), 32'(o_sv[k]), 32'(rem[k] > 0));
                check_val($sformatf("sw%0d_busy", w), 32'(o_busy[k]), 32'(rem[k] > 0));
                check_val($sformatf("sw%0d_done", w), 32'(o_done[k]), 32'(done_exp[k]));
                if (rem[k] > 0)
                    check_val($sformatf("sw%0d_sout", w), 32'(o_sout[k]), 32'(cur[k][w - rem[k]]));
                else
                    check_val($sformatf("sw%0d_sout_idle", w), 32'(o_sout[k]), 32'd0);
            end
            if (c < ncyc) begin
                sw_load = ($urandom_range(0, 2) == 0);
                sw_in   = 16'($urandom);
                sw_sr   = ($urandom_range(0, 3) != 0);
            end else begin
                sw_load = 1'b0;
                sw_sr   = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? 2 : 16;
                mask = (32'h1 << w) - 32'h1;
                done_exp[k] = 1'b0;
                if (rem[k] == 0) begin
                    if (sw_load) begin
                        cur[k] = sw_in & mask[15:0];
                        rem[k] = w;
                        rxw[k] = 16'h0;
                        acc[k]++;
                    end
                end else if (sw_sr) begin
                    rxw[k][w - rem[k]] = o_sout[k];
                    rem[k]--;
                    if (rem[k] == 0) begin
                        done_exp[k] = 1'b1;
                        check_val($sformatf("sw%0d_word", w), 32'(rxw[k]), 32'(cur[k]));
                    end
                end
            end
            @(negedge clk);
        end
        check_val("sw2_done_count", 32'(done_cnt2), 32'(acc[0]));
        check_val("sw16_done_count", 32'(done_cnt16), 32'(acc[1]));
    endtask

    initial begin
        int d0;
        reset_n = 1'b1;
        load4 = 1'b0; in4 = 4'h0; sr4 = 1'b1;
        sw_load = 1'b0; sw_in = 16'h0; sw_sr = 1'b0;

        // Reset values, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_sout", 32'(sout4), 32'd0);
        check_val("rst_svalid", 32'(sv4), 32'd0);
        check_val("rst_busy", 32'(busy4), 32'd0);
        check_val("rst_done", 32'(done4), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic word.
        load4_word(4'b1011);
        expect_seq(4'b1011, "basic");
        @(negedge clk);
        check_val("basic_done_once", 32'(done4), 32'd0);

        // Stall with sready low for three cycles.
        load4_word(4'b0110);
        sr4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_sout", 32'(sout4), 32'd0);
            check_val("stall_svalid", 32'(sv4), 32'd1);
            check_val("stall_busy", 32'(busy4), 32'd1);
            @(negedge clk);
        end
        sr4 = 1'b1;
        expect_seq(4'b0110, "stall");
        @(negedge clk);

        // Load while busy, held through the last-bit cycle.
        d0 = done_cnt4;
        load4_word(4'b0001);
        for (int i = 0; i < 4; i++) begin
            check_val("lwb_sout", 32'(sout4), 32'(i == 0));
            load4 = 1'b1;
            in4   = 4'b1111;
            @(negedge clk);
        end
        load4 = 1'b0;
        check_val("lwb_done", 32'(done4), 32'd1);
        check_val("lwb_busy_end", 32'(busy4), 32'd0);
        @(negedge clk);
        check_val("lwb_idle_svalid", 32'(sv4), 32'd0);
        check_val("lwb_done_count", 32'(done_cnt4 - d0), 32'd1);

        // Back-to-back words.
        d0 = done_cnt4;
        load4_word(4'b1100);
        expect_seq(4'b1100, "b2b_a");
        load4_word(4'b1010);
        check_val("b2b_done_single", 32'(done4), 32'd0);
        expect_seq(4'b1010, "b2b_b");
        @(negedge clk);
        check_val("b2b_done_count", 32'(done_cnt4 - d0), 32'd2);

        // Asynchronous reset after two bits.
        load4_word(4'b0101);
        repeat (2) @(negedge clk);
        check_val("arst_pre_sout", 32'(sout4), 32'd1);
        d0 = done_cnt4;
        #1 reset_n = 1'b0;
        #1;
        check_val("arst_svalid", 32'(sv4), 32'd0);
        check_val("arst_busy", 32'(busy4), 32'd0);
        check_val("arst_sout", 32'(sout4), 32'd0);
        #4 reset_n = 1'b1;
        @(negedge clk);
        check_val("arst_idle_svalid", 32'(sv4), 32'd0);
        check_val("arst_no_done", 32'(done_cnt4 - d0), 32'd0);
        load4_word(4'b0011);
        expect_seq(4'b0011, "arst_reload");
        @(negedge clk);

        // Randomized sweep on WIDTH=2 and WIDTH=16.
        sweep(600);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the parallel word width in bits; legal range 2..16.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset_ SHALL be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 Port load SHALL be an input, 1 bit, a request to capture in[] for transmission.
REQ-005 Port in SHALL be an input, WIDTH bits, the parallel word to transmit.
REQ-006 Port sready SHALL be an input, 1 bit, meaning the downstream receiver accepts the current serial bit.
REQ-007 Port sout SHALL be an output, 1 bit, the current serial data bit.
REQ-008 Port svalid SHALL be an output, 1 bit, meaning sout holds a valid bit.
REQ-009 Port busy SHALL be an output, 1 bit, meaning a word is in flight and load is ignored.
REQ-010 Port done SHALL be an output, 1 bit, a single-cycle pulse marking word completion.

Function
REQ-011 The block SHALL implement two states: IDLE and SHIFT.
REQ-012 In IDLE with load=1 at a rising edge, the block SHALL capture in[] into a WIDTH-bit shift register, set the bit counter to WIDTH-1 and enter SHIFT.
REQ-013 In IDLE with load=0, the block SHALL remain in IDLE and hold all state.
REQ-014 Latency: after a load captured at edge k, svalid=1 and busy=1 SHALL be visible from edge k until the word completes.
REQ-015 In SHIFT, sout SHALL equal shift register bit 0, so the word is sent LSB first.
REQ-016 A bit SHALL transfer only on a rising edge where svalid=1 and sready=1.
REQ-017 On a transfer, the register SHALL shift right by one with 0 filled at the MSB, and the counter SHALL decrement by one.
REQ-018 With sready=0 in SHIFT, sout, the shift register and the counter SHALL all hold, for any number of cycles.
REQ-019 A transfer with counter=0 is the last bit; at that edge the block SHALL enter IDLE, and svalid and busy SHALL read 0 from that edge.
REQ-020 done SHALL be 1 for exactly the one cycle following the last-bit transfer edge, and 0 otherwise.
REQ-021 A load asserted while busy=1 SHALL be ignored, including the cycle of the last-bit transfer; the word in flight SHALL NOT be corrupted.
REQ-022 Back-to-back operation: a load in the cycle where done=1 SHALL be accepted, giving one idle cycle between words.
REQ-023 In IDLE, sout SHALL be 0 and svalid SHALL be 0.
REQ-024 in[] SHALL be sampled only at the capture edge; later changes to in[] SHALL have no effect on the word in flight.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap below 0.
REQ-026 Exactly WIDTH transfers SHALL occur per captured word.

Reset
REQ-027 While reset_=0, the block SHALL immediately, without waiting for clk, force state=IDLE, shift register=0, counter=0, sout=0, svalid=0, busy=0 and done=0.
REQ-028 Reset asserted mid-word SHALL abort the word; no done pulse SHALL follow.
REQ-029 After reset_ rises, the first load SHALL be accepted on the first clk edge with reset_=1.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Verification
REQ-031 The bench SHALL cover a basic word: WIDTH=4, in=4'b1011, load pulse, sready=1 -> sout sequence 1,1,0,1 over 4 cycles, then done=1 for one cycle, busy=0.
REQ-032 The bench SHALL cover stalls: in=4'b0110 with sready held low 3 cycles after the first bit -> sout holds 0 during the stall, and the full sequence 0,1,1,0 is completed with no bit lost or duplicated.
REQ-033 The bench SHALL cover load while busy: load in=4'b1111 during transmission of 4'b0001 -> output stays 1,0,0,0 and exactly one done pulse occurs.
REQ-034 The bench SHALL cover back-to-back words: load 4'b1010 in the done cycle of a prior word -> the second word 0,1,0,1 starts next cycle and produces a second done pulse.
REQ-035 The bench SHALL cover async reset: reset_ low for half a clock period after bit 2 -> svalid, busy and sout fall to 0 before the next edge and no done pulse occurs; a subsequent load of 4'b0011 transmits correctly.
REQ-036 The bench SHALL cover a parameter sweep: WIDTH=2 and WIDTH=16 with random data and random sready -> the received word equals the loaded word, and done count equals load-accept count.
